// File: rtl/hwpe_cfg_router.sv
// Routes single-outstanding config transactions to one of N_HWPE engines,
// with timeout/bad-index error responses and event/busy aggregation.
module hwpe_cfg_router #(
    parameter int unsigned N_HWPE   = 2,
    parameter int unsigned N_CORES  = 8,
    parameter int unsigned ID_WIDTH = 8,
    parameter int unsigned SEL_LSB  = 8,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 cfg_req_i,
    input  logic                                 cfg_wen_i,
    input  logic [31:0]                          cfg_add_i,
    input  logic [31:0]                          cfg_wdata_i,
    input  logic [3:0]                           cfg_be_i,
    input  logic [ID_WIDTH-1:0]                  cfg_id_i,
    output logic                                 cfg_gnt_o,
    output logic                                 cfg_r_valid_o,
    output logic [31:0]                          cfg_r_rdata_o,
    output logic [ID_WIDTH-1:0]                  cfg_r_id_o,
    output logic [N_HWPE-1:0]                    hwpe_req_o,
    output logic [31:0]                          hwpe_add_o,
    output logic [31:0]                          hwpe_data_o,
    output logic                                 hwpe_wen_o,
    output logic [3:0]                           hwpe_be_o,
    output logic [ID_WIDTH-1:0]                  hwpe_id_o,
    input  logic [N_HWPE-1:0]                    hwpe_gnt_i,
    input  logic [N_HWPE-1:0]                    hwpe_r_valid_i,
    input  logic [N_HWPE-1:0]                    hwpe_busy_i,
    input  logic [N_HWPE-1:0][31:0]              hwpe_r_data_i,
    input  logic [N_HWPE-1:0][N_CORES-1:0][1:0]  hwpe_evt_i,
    output logic [N_CORES-1:0][1:0]              evt_o,
    output logic                                 busy_o,
    output logic                                 err_o
);

    localparam int unsigned SEL_W = (N_HWPE > 1) ? $clog2(N_HWPE) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                    state_q, state_d;
    logic [SEL_W-1:0]          sel;
    logic                      sel_ok;
    logic [SEL_W-1:0]          idx_q;
    logic [31:0]               add_q, wdata_q, data_q;
    logic                      wen_q, err_q, busy_q;
    logic [3:0]                be_q;
    logic [ID_WIDTH-1:0]       id_q;
    logic [15:0]               cnt_q;
    logic                      tmo;
    logic [N_HWPE-1:0]         sel_hit;
    logic                      gnt_sel, rv_sel;
    logic [31:0]               rdata_sel;
    logic [N_CORES-1:0][1:0]   evt_or, evt_q;

    assign sel    = cfg_add_i[SEL_LSB +: SEL_W];
    assign sel_ok = 32'(sel) < N_HWPE;
    assign tmo    = 32'(cnt_q) >= (TIMEOUT - 1);

    // Decode the latched index once; every per-engine mux keys off it.
    always_comb begin
        sel_hit   = '0;
        rdata_sel = '0;
        for (int e = 0; e < int'(N_HWPE); e++) begin
            sel_hit[e] = (32'(idx_q) == 32'(e));
            if (sel_hit[e]) rdata_sel = hwpe_r_data_i[e];
        end
    end

    assign gnt_sel = |(hwpe_gnt_i & sel_hit);
    assign rv_sel  = |(hwpe_r_valid_i & sel_hit);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (cfg_req_i) state_d = sel_ok ? REQ : RESP;
            REQ: begin
                if (gnt_sel && rv_sel) state_d = RESP;
                else if (tmo)          state_d = RESP;
                else if (gnt_sel)      state_d = WAIT;
            end
            WAIT: if (rv_sel || tmo) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q   <= '0;
            add_q   <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            be_q    <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (cfg_req_i) begin
                    idx_q   <= sel;
                    add_q   <= cfg_add_i;
                    wdata_q <= cfg_wdata_i;
                    wen_q   <= cfg_wen_i;
                    be_q    <= cfg_be_i;
                    id_q    <= cfg_id_i;
                    cnt_q   <= '0;
                    err_q   <= !sel_ok;
                end
                REQ: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (gnt_sel && rv_sel) data_q <= rdata_sel;
                    else if (tmo)          err_q  <= 1'b1;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (rv_sel)   data_q <= rdata_sel;
                    else if (tmo) err_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        evt_or = '0;
        for (int e = 0; e < int'(N_HWPE); e++) evt_or = evt_or | hwpe_evt_i[e];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            evt_q  <= '0;
        end else begin
            busy_q <= (|hwpe_busy_i) || (state_q != IDLE);
            evt_q  <= evt_or;
        end
    end

    // Outputs are gated by rst_i so they read zero during the reset cycle itself.
    always_comb begin
        cfg_gnt_o     = !rst_i && (state_q == IDLE) && cfg_req_i;
        cfg_r_valid_o = !rst_i && (state_q == RESP);
        err_o         = cfg_r_valid_o && err_q;
        cfg_r_rdata_o = '0;
        cfg_r_id_o    = '0;
        if (cfg_r_valid_o) begin
            cfg_r_rdata_o = err_q ? 32'hDEAD_BEEF : data_q;
            cfg_r_id_o    = id_q;
        end
        hwpe_req_o = '0;
        if (!rst_i && (state_q == REQ)) hwpe_req_o = sel_hit;
        busy_o = !rst_i && busy_q;
        evt_o  = rst_i ? '0 : evt_q;
    end

    assign hwpe_add_o  = add_q;
    assign hwpe_data_o = wdata_q;
    assign hwpe_wen_o  = wen_q;
    assign hwpe_be_o   = be_q;
    assign hwpe_id_o   = id_q;

endmodule

// File: tb/tb_hwpe_cfg_router.sv
// Directed bench for hwpe_cfg_router: a long-timeout instance (a)
// and a TIMEOUT=4 instance (b) sharing all inputs except cfg_req.
module tb_hwpe_cfg_router;

    localparam int NH = 3;
    localparam int NC = 8;
    localparam int IW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst;
    logic                       cfg_req, cfg_req_b, cfg_wen;
    logic [31:0]                cfg_add, cfg_wdata;
    logic [3:0]                 cfg_be;
    logic [IW-1:0]              cfg_id;
    logic [NH-1:0]              h_gnt, h_rv, h_busy;
    logic [NH-1:0][31:0]        h_data;
    logic [NH-1:0][NC-1:0][1:0] h_evt;

    logic                gnt_a, rv_a, wen_a, busy_a, err_a;
    logic [31:0]         rdata_a, hadd_a, hdata_a;
    logic [IW-1:0]       rid_a, hid_a;
    logic [NH-1:0]       hreq_a;
    logic [3:0]          hbe_a;
    logic [NC-1:0][1:0]  evt_a;

    logic                gnt_b, rv_b, wen_b, busy_b, err_b;
    logic [31:0]         rdata_b, hadd_b, hdata_b;
    logic [IW-1:0]       rid_b, hid_b;
    logic [NH-1:0]       hreq_b;
    logic [3:0]          hbe_b;
    logic [NC-1:0][1:0]  evt_b;

    hwpe_cfg_router #(.N_HWPE(NH), .N_CORES(NC), .ID_WIDTH(IW),
                      .SEL_LSB(8), .TIMEOUT(255)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .cfg_req_i(cfg_req), .cfg_wen_i(cfg_wen),
        .cfg_add_i(cfg_add), .cfg_wdata_i(cfg_wdata),
        .cfg_be_i(cfg_be), .cfg_id_i(cfg_id),
        .cfg_gnt_o(gnt_a), .cfg_r_valid_o(rv_a),
        .cfg_r_rdata_o(rdata_a), .cfg_r_id_o(rid_a),
        .hwpe_req_o(hreq_a), .hwpe_add_o(hadd_a),
        .hwpe_data_o(hdata_a), .hwpe_wen_o(wen_a),
        .hwpe_be_o(hbe_a), .hwpe_id_o(hid_a),
        .hwpe_gnt_i(h_gnt), .hwpe_r_valid_i(h_rv),
        .hwpe_busy_i(h_busy), .hwpe_r_data_i(h_data),
        .hwpe_evt_i(h_evt), .evt_o(evt_a),
        .busy_o(busy_a), .err_o(err_a)
    );

    hwpe_cfg_router #(.N_HWPE(NH), .N_CORES(NC), .ID_WIDTH(IW),
                      .SEL_LSB(8), .TIMEOUT(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .cfg_req_i(cfg_req_b), .cfg_wen_i(cfg_wen),
        .cfg_add_i(cfg_add), .cfg_wdata_i(cfg_wdata),
        .cfg_be_i(cfg_be), .cfg_id_i(cfg_id),
        .cfg_gnt_o(gnt_b), .cfg_r_valid_o(rv_b),
        .cfg_r_rdata_o(rdata_b), .cfg_r_id_o(rid_b),
        .hwpe_req_o(hreq_b), .hwpe_add_o(hadd_b),
        .hwpe_data_o(hdata_b), .hwpe_wen_o(wen_b),
        .hwpe_be_o(hbe_b), .hwpe_id_o(hid_b),
        .hwpe_gnt_i(h_gnt), .hwpe_r_valid_i(h_rv),
        .hwpe_busy_i(h_busy), .hwpe_r_data_i(h_data),
        .hwpe_evt_i(h_evt), .evt_o(evt_b),
        .busy_o(busy_b), .err_o(err_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  busy;
        logic [15:0] e0, e1, e2;
        logic        exp_busy;
        logic [15:0] exp_evt;
    } vec_t;

    vec_t tbl [6];

    int  n_req;
    bit  seen;

    initial begin
        // evt bit index is core*2+bit; 0x0080 is core 3, bit 1
        tbl[0] = '{3'b000, 16'h0080, 16'h0080, 16'h0000, 1'b0, 16'h0080};
        tbl[1] = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        tbl[2] = '{3'b001, 16'h0001, 16'h0100, 16'h8000, 1'b1, 16'h8101};
        tbl[3] = '{3'b100, 16'h0002, 16'h0000, 16'h0000, 1'b1, 16'h0002};
        tbl[4] = '{3'b010, 16'h00F0, 16'h0F00, 16'h00FF, 1'b1, 16'h0FFF};
        tbl[5] = '{3'b000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000};

        rst = 1'b1;
        cfg_req = 1'b1; cfg_req_b = 1'b1; cfg_wen = 1'b1;
        cfg_add = '0; cfg_wdata = '0; cfg_be = 4'hF; cfg_id = '0;
        h_gnt = '0; h_rv = '0; h_busy = '0; h_data = '0; h_evt = '0;
        tick();
        tick();
        chk("rst_gnt", {31'd0, gnt_a}, 32'd0);
        chk("rst_gnt_b", {31'd0, gnt_b}, 32'd0);
        chk("rst_rvalid", {31'd0, rv_a}, 32'd0);
        chk("rst_hreq", {29'd0, hreq_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_err", {31'd0, err_a}, 32'd0);
        chk("rst_rdata", rdata_a, 32'd0);
        chk("rst_rid", {24'd0, rid_a}, 32'd0);
        rst = 1'b0; cfg_req = 1'b0; cfg_req_b = 1'b0;

        // Event/busy aggregation table
        for (int i = 0; i < 6; i++) begin
            h_busy = tbl[i].busy;
            h_evt[0] = tbl[i].e0;
            h_evt[1] = tbl[i].e1;
            h_evt[2] = tbl[i].e2;
            tick();
            chk($sformatf("busy_v%0d", i), {31'd0, busy_a},
                {31'd0, tbl[i].exp_busy});
            chk($sformatf("evt_v%0d", i), {16'd0, evt_a},
                {16'd0, tbl[i].exp_evt});
        end
        h_busy = '0; h_evt = '0;
        tick();

        // Normal read from engine 1
        cfg_req = 1'b1; cfg_add = 32'h100; cfg_id = 8'h5A; cfg_wen = 1'b1;
        #1 chk("rd_gnt", {31'd0, gnt_a}, 32'd1);
        tick();
        cfg_req = 1'b0;
        chk("rd_req1", {29'd0, hreq_a}, 32'b010);
        chk("rd_gnt_off", {31'd0, gnt_a}, 32'd0);
        chk("rd_hid", {24'd0, hid_a}, 32'h5A);
        tick();
        h_gnt[1] = 1'b1;
        chk("rd_req2", {29'd0, hreq_a}, 32'b010);
        tick();
        h_gnt = '0;
        chk("rd_req_drop", {29'd0, hreq_a}, 32'd0);
        chk("rd_busy", {31'd0, busy_a}, 32'd1);
        h_rv[0] = 1'b1; h_data[0] = 32'h0000_BAD0;
        tick();
        h_rv = '0;
        chk("rd_other_rv", {31'd0, rv_a}, 32'd0);
        tick();
        h_rv[1] = 1'b1; h_data[1] = 32'h1234_5678;
        chk("rd_wait3", {31'd0, rv_a}, 32'd0);
        tick();
        h_rv = '0;
        chk("rd_rvalid", {31'd0, rv_a}, 32'd1);
        chk("rd_rdata", rdata_a, 32'h1234_5678);
        chk("rd_rid", {24'd0, rid_a}, 32'h5A);
        chk("rd_err", {31'd0, err_a}, 32'd0);
        tick();
        chk("rd_rvalid_once", {31'd0, rv_a}, 32'd0);

        // Out-of-range engine index
        cfg_req = 1'b1; cfg_add = 32'h300; cfg_id = 8'h77; cfg_wen = 1'b0;
        #1 chk("bad_gnt", {31'd0, gnt_a}, 32'd1);
        tick();
        cfg_req = 1'b0;
        chk("bad_rvalid", {31'd0, rv_a}, 32'd1);
        chk("bad_rdata", rdata_a, 32'hDEAD_BEEF);
        chk("bad_err", {31'd0, err_a}, 32'd1);
        chk("bad_rid", {24'd0, rid_a}, 32'h77);
        chk("bad_hreq", {29'd0, hreq_a}, 32'd0);
        tick();
        chk("bad_rvalid_once", {31'd0, rv_a}, 32'd0);
        chk("bad_err_once", {31'd0, err_a}, 32'd0);
        chk("bad_hreq2", {29'd0, hreq_a}, 32'd0);

        // Back-to-back, engine 0 grants and responds in the same cycle
        cfg_req = 1'b1; cfg_add = 32'h000; cfg_id = 8'h11; cfg_wen = 1'b1;
        h_gnt[0] = 1'b1; h_rv[0] = 1'b1; h_data[0] = 32'hA0A0_A0A0;
        #1 chk("b2b_gnt1", {31'd0, gnt_a}, 32'd1);
        tick();
        cfg_id = 8'h22;
        chk("b2b_gnt_req", {31'd0, gnt_a}, 32'd0);
        chk("b2b_hreq", {29'd0, hreq_a}, 32'b001);
        tick();
        chk("b2b_rv1", {31'd0, rv_a}, 32'd1);
        chk("b2b_id1", {24'd0, rid_a}, 32'h11);
        chk("b2b_data1", rdata_a, 32'hA0A0_A0A0);
        chk("b2b_gnt_resp", {31'd0, gnt_a}, 32'd0);
        tick();
        chk("b2b_gnt2", {31'd0, gnt_a}, 32'd1);
        chk("b2b_rv_idle", {31'd0, rv_a}, 32'd0);
        tick();
        cfg_req = 1'b0;
        h_data[0] = 32'hB0B0_B0B0;
        tick();
        chk("b2b_rv2", {31'd0, rv_a}, 32'd1);
        chk("b2b_id2", {24'd0, rid_a}, 32'h22);
        chk("b2b_data2", rdata_a, 32'hB0B0_B0B0);
        h_gnt = '0; h_rv = '0;
        tick();

        // Timeout on instance b (TIMEOUT=4), engine never grants
        cfg_req_b = 1'b1; cfg_add = 32'h000; cfg_id = 8'h33;
        #1 chk("to_gnt", {31'd0, gnt_b}, 32'd1);
        tick();
        cfg_req_b = 1'b0;
        n_req = 0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (rv_b) begin
                seen = 1'b1;
                break;
            end
            if (hreq_b[0]) n_req++;
            tick();
        end
        chk("to_resp_seen", {31'd0, seen}, 32'd1);
        chk("to_req_cycles", n_req, 32'd4);
        chk("to_err", {31'd0, err_b}, 32'd1);
        chk("to_rdata", rdata_b, 32'hDEAD_BEEF);
        chk("to_rid", {24'd0, rid_b}, 32'h33);
        chk("to_hreq_off", {29'd0, hreq_b}, 32'd0);
        tick();
        h_rv[0] = 1'b1; h_data[0] = 32'h0000_0055;
        chk("to_rv_once", {31'd0, rv_b}, 32'd0);
        tick();
        chk("to_late_rv1", {31'd0, rv_b}, 32'd0);
        tick();
        h_rv = '0;
        chk("to_late_rv2", {31'd0, rv_b}, 32'd0);

        // Reset while in WAIT
        cfg_req = 1'b1; cfg_add = 32'h200; cfg_id = 8'h44;
        tick();
        cfg_req = 1'b0; h_gnt[2] = 1'b1;
        tick();
        h_gnt = '0;
        tick();
        rst = 1'b1; cfg_req = 1'b1;
        #1;
        chk("mrst_hreq", {29'd0, hreq_a}, 32'd0);
        chk("mrst_gnt", {31'd0, gnt_a}, 32'd0);
        chk("mrst_rv", {31'd0, rv_a}, 32'd0);
        chk("mrst_err", {31'd0, err_a}, 32'd0);
        chk("mrst_busy", {31'd0, busy_a}, 32'd0);
        chk("mrst_evt", {16'd0, evt_a}, 32'd0);
        chk("mrst_rdata", rdata_a, 32'd0);
        chk("mrst_rid", {24'd0, rid_a}, 32'd0);
        tick();
        rst = 1'b0;
        cfg_id = 8'h45;
        h_rv[2] = 1'b1; h_data[2] = 32'hCAFE_0000;
        #1;
        chk("post_rst_gnt", {31'd0, gnt_a}, 32'd1);
        chk("post_rst_rv", {31'd0, rv_a}, 32'd0);
        tick();
        cfg_req = 1'b0;
        chk("post_rst_rv2", {31'd0, rv_a}, 32'd0);
        chk("post_rst_hreq", {29'd0, hreq_a}, 32'b100);
        h_gnt[2] = 1'b1; h_data[2] = 32'h600D_F00D;
        tick();
        h_gnt = '0; h_rv = '0;
        chk("post_rst_resp", {31'd0, rv_a}, 32'd1);
        chk("post_rst_data", rdata_a, 32'h600D_F00D);
        chk("post_rst_id", {24'd0, rid_a}, 32'h45);
        chk("post_rst_err", {31'd0, err_a}, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
